// File: rtl/clock_divider_prog.sv
// clock_divider_prog: runtime-programmable clock divider.
// Produces a near-50% divided clock (o_clk) and a one-cycle wrap strobe (o_tick).
// A new divisor is held as pending and only switches in at a period boundary
// (wrap or clear), so the output never shows a runt or stretched pulse.
// Optional feature macro: CLKDIV_DIGIT_SEL_EN adds o_digit_sel[1:0], a 2-bit
// scan index that advances on every tick.
//
// The period position is tracked as a down-counter "rem" = P-1-c. The wrap is
// the terminal count rem==0, and the high phase is rem < (P>>1), which is the
// same as c >= P-(P>>1).
module clock_divider_prog #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned DIV_DEFAULT = 100_000
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_en,
   input  logic             i_clear,
   input  logic [CNT_W-1:0] i_div,
   input  logic             i_div_load,
   output logic             o_clk,
   output logic             o_tick,
   output logic [CNT_W-1:0] o_div_active,
`ifdef CLKDIV_DIGIT_SEL_EN
   output logic [1:0]       o_digit_sel,
`endif
   output logic             o_load_pending
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
   localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] rem;
   logic [CNT_W-1:0] div_active;
   logic [CNT_W-1:0] div_pend;
   logic             pend_flag;
   logic             clk_q;
   logic             tick_q;

   logic [CNT_W-1:0] load_val;
   logic             wrap;
   logic             restart;
   logic [CNT_W-1:0] div_next;
   logic [CNT_W-1:0] half_next;
   logic [CNT_W-1:0] rem_next;
   logic             clk_next;
   logic             pend_flag_next;
   logic [CNT_W-1:0] div_pend_next;

   // next-state: a restart (wrap or clear) is the only point where the divisor may change
   always_comb begin
      load_val       = (i_div < DIV_MIN) ? DIV_MIN : i_div;
      wrap           = i_en && !i_clear && (rem == '0);
      restart        = i_clear || wrap;
      div_next       = (restart && pend_flag) ? div_pend : div_active;
      half_next      = div_next >> 1;
      rem_next       = rem;
      if (restart) begin
         rem_next = div_next - ONE;
      end else if (i_en) begin
         rem_next = rem - ONE;
      end
      clk_next       = (rem_next < half_next);
      pend_flag_next = pend_flag;
      if (i_div_load) begin
         pend_flag_next = 1'b1;
      end else if (restart) begin
         pend_flag_next = 1'b0;
      end
      div_pend_next  = i_div_load ? load_val : div_pend;
   end

   // divider state, divided clock and wrap strobe
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rem        <= DIV_RST - ONE;
         div_active <= DIV_RST;
         div_pend   <= DIV_RST;
         pend_flag  <= 1'b0;
         clk_q      <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         rem        <= rem_next;
         div_active <= div_next;
         div_pend   <= div_pend_next;
         pend_flag  <= pend_flag_next;
         clk_q      <= clk_next;
         tick_q     <= wrap;
      end
   end

`ifdef CLKDIV_DIGIT_SEL_EN
   logic [1:0] digit_sel;

   // display scan index: advances with each tick, restarts on clear
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         digit_sel <= 2'd0;
      end else if (i_clear) begin
         digit_sel <= 2'd0;
      end else if (wrap) begin
         digit_sel <= digit_sel + 2'd1;
      end
   end

   assign o_digit_sel = digit_sel;
`endif

   assign o_clk          = clk_q;
   assign o_tick         = tick_q;
   assign o_div_active   = div_active;
   assign o_load_pending = pend_flag;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog, built with DIV_DEFAULT=10. Honours CLKDIV_DIGIT_SEL_EN.
module tb_clock_divider_prog;

   localparam int CNT_W   = 32;
   localparam int DIV_DEF = 10;

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b0;
   logic             en     = 1'b0;
   logic             clr    = 1'b0;
   logic             ld     = 1'b0;
   logic [CNT_W-1:0] div    = '0;
   logic             dclk;
   logic             tick;
   logic [CNT_W-1:0] act;
   logic             pend;
`ifdef CLKDIV_DIGIT_SEL_EN
   logic [1:0]       dsel;
`endif

   always #5 clk = ~clk;

   clock_divider_prog #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEF)
   ) dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_en           (en),
      .i_clear        (clr),
      .i_div          (div),
      .i_div_load     (ld),
      .o_clk          (dclk),
      .o_tick         (tick),
      .o_div_active   (act),
`ifdef CLKDIV_DIGIT_SEL_EN
      .o_digit_sel    (dsel),
`endif
      .o_load_pending (pend)
   );

   typedef struct {
      logic             en;
      logic             clr;
      logic             ld;
      logic [CNT_W-1:0] div;
      logic             clk;
      logic             tick;
      logic [CNT_W-1:0] act;
      logic             pend;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void vec(input logic ven, input logic vclr, input logic vld,
                               input logic [CNT_W-1:0] vdiv, input logic eclk,
                               input logic etick, input logic [CNT_W-1:0] eact,
                               input logic epend);
      vec_t v;
      v.en = ven; v.clr = vclr; v.ld = vld; v.div = vdiv;
      v.clk = eclk; v.tick = etick; v.act = eact; v.pend = epend;
      vecs.push_back(v);
   endfunction

   // n plain enabled cycles of period p starting from position c_prev
   function automatic void run(input int n, input int c_prev, input int p, input logic epend);
      int c;
      c = c_prev;
      for (int i = 0; i < n; i++) begin
         c = (c + 1) % p;
         vec(1'b1, 1'b0, 1'b0, '0, logic'(c >= p - p / 2), logic'(c == 0), CNT_W'(p), epend);
      end
   endfunction

   task automatic check(input string name, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      // edges 1..20: P=10, load 7 at c=3, switch at wrap
      run(13, 0, 10, 1'b0);
      vec(1, 0, 1, 7, 0, 0, 10, 1);
      run(5, 4, 10, 1'b1);
      vec(1, 0, 0, 0, 0, 1, 7, 0);
      // P=7 for two periods
      run(14, 0, 7, 1'b0);
      // loads of 0 then 1 clamp to 2
      vec(1, 0, 1, 0, 0, 0, 7, 1);
      vec(1, 0, 1, 1, 0, 0, 7, 1);
      run(4, 2, 7, 1'b1);
      vec(1, 0, 0, 0, 0, 1, 2, 0);
      run(4, 0, 2, 1'b0);
      // back to P=10
      vec(1, 0, 1, 10, 1, 0, 2, 1);
      vec(1, 0, 0, 0, 0, 1, 10, 0);
      // pause 3 cycles at c=6: this period lasts 13, the next 10
      run(6, 0, 10, 1'b0);
      vec(0, 0, 0, 0, 1, 0, 10, 0);
      vec(0, 0, 0, 0, 1, 0, 10, 0);
      vec(0, 0, 0, 0, 1, 0, 10, 0);
      run(14, 6, 10, 1'b0);
      // load 4 while disabled, clear at c=7 applies it
      run(6, 0, 10, 1'b0);
      vec(0, 0, 1, 4, 1, 0, 10, 1);
      vec(1, 0, 0, 0, 1, 0, 10, 1);
      vec(1, 1, 0, 0, 0, 0, 4, 0);
      run(4, 0, 4, 1'b0);
      // load on the wrap cycle applies at the following wrap
      run(3, 0, 4, 1'b0);
      vec(1, 0, 1, 6, 0, 1, 4, 1);
      run(3, 0, 4, 1'b1);
      vec(1, 0, 0, 0, 0, 1, 6, 0);
      // load 5 pending, then clear together with load 9
      vec(1, 0, 1, 5, 0, 0, 6, 1);
      vec(1, 1, 1, 9, 0, 0, 5, 1);
      run(4, 0, 5, 1'b1);
      vec(1, 0, 0, 0, 0, 1, 9, 0);
      // clear wins over a low enable
      run(1, 0, 9, 1'b0);
      vec(0, 1, 0, 0, 0, 0, 9, 0);
      run(9, 0, 9, 1'b0);

      repeat (2) @(negedge clk);
      check("reset clk", CNT_W'(dclk), 0);
      check("reset tick", CNT_W'(tick), 0);
      check("reset div_active", act, DIV_DEF);
      check("reset pending", CNT_W'(pend), 0);
`ifdef CLKDIV_DIGIT_SEL_EN
      check("reset digit_sel", CNT_W'(dsel), 0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         en = vecs[i].en; clr = vecs[i].clr; ld = vecs[i].ld; div = vecs[i].div;
         @(posedge clk);
         #1;
         check($sformatf("edge%0d clk", i + 1), CNT_W'(dclk), CNT_W'(vecs[i].clk));
         check($sformatf("edge%0d tick", i + 1), CNT_W'(tick), CNT_W'(vecs[i].tick));
         check($sformatf("edge%0d div_active", i + 1), act, vecs[i].act);
         check($sformatf("edge%0d pending", i + 1), CNT_W'(pend), CNT_W'(vecs[i].pend));
         @(negedge clk);
      end

      // async reset at c=8 with a load pending
      en = 1'b1; clr = 1'b0; ld = 1'b0; div = '0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (7) @(negedge clk);
      ld = 1'b1; div = 3;
      @(posedge clk);
      #1;
      ld = 1'b0;
      check("pre-reset clk", CNT_W'(dclk), 1);
      check("pre-reset pending", CNT_W'(pend), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async reset clk", CNT_W'(dclk), 0);
      check("async reset tick", CNT_W'(tick), 0);
      check("async reset div_active", act, DIV_DEF);
      check("async reset pending", CNT_W'(pend), 0);
`ifdef CLKDIV_DIGIT_SEL_EN
      check("async reset digit_sel", CNT_W'(dsel), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("post-reset %0d tick", i), CNT_W'(tick), CNT_W'(i % 10 == 0));
         check($sformatf("post-reset %0d clk", i), CNT_W'(dclk), CNT_W'(i % 10 >= 5));
         check($sformatf("post-reset %0d div_active", i), act, DIV_DEF);
`ifdef CLKDIV_DIGIT_SEL_EN
         check($sformatf("post-reset %0d digit_sel", i), CNT_W'(dsel), CNT_W'((i / 10) % 4));
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
Runtime-programmable clock divider. It is the parametrised successor of the fixed digit-scan divider. It produces a near-50% divided clock and a one-cycle tick strobe from the system clock, with enable, synchronous clear, and a glitch-free divisor change at the period boundary. It feeds display-scan and count-rate logic in the counter design.

Parameters:
CNT_W, 32, width of counter and divisor registers
DIV_DEFAULT, 100_000, divisor after reset: full output period in i_clk cycles (100 MHz -> 1 kHz); must be >= 2

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_en  input  1  count enable; low freezes the divider
i_clear  input  1  synchronous restart of the period
i_div  input  CNT_W  new divisor value (full period)
i_div_load  input  1  one-cycle strobe; captures i_div
o_clk  output  1  divided clock (registered)
o_tick  output  1  one-cycle strobe at each period wrap (registered)
o_div_active  output  CNT_W  divisor currently in use
o_load_pending  output  1  a captured divisor is waiting for the next wrap

Behaviour:
- Reset (i_reset_n=0, asynchronous):
  - counter c=0, o_clk=0, o_tick=0.
  - o_div_active=DIV_DEFAULT, pending register=DIV_DEFAULT, o_load_pending=0.
- Period definitions:
  - P=o_div_active, L=P-(P>>1) (low phase, ceil), H=P>>1 (high phase, floor).
- Counting (i_en=1, i_clear=0):
  - c increments 0..P-1, then wraps to 0.
  - o_clk is registered alongside c: o_clk=1 exactly while c is in [L, P-1], else 0.
  - Even P gives a 50% duty cycle. Odd P gives low=ceil(P/2), high=floor(P/2).
- Tick:
  - o_tick=1 for exactly one cycle: the cycle in which c==0 after a wrap from P-1.
  - o_tick is never asserted after reset or after clear.
  - The first tick after reset comes P cycles after the first enabled edge.
- i_en=0:
  - c and o_clk hold, o_tick=0, and the period is stretched by the number of disabled cycles.
  - Loads are still captured.
- i_clear=1 (priority over i_en):
  - Next cycle: c=0, o_clk=0, o_tick=0.
  - If a load is pending, it is applied in the same cycle and o_load_pending clears.
- Divisor load:
  - i_div_load=1 captures max(i_div,2) into the pending register and sets o_load_pending=1. Values 0 and 1 clamp to 2.
  - The pending value is copied to o_div_active on the wrap edge (c P-1->0) and o_load_pending clears.
  - The new period starts at c=0, so no runt or stretched pulse occurs.
  - A second load before the wrap overwrites the pending value (last one wins).
  - A load in the same cycle as a wrap is captured as pending and applies at the following wrap; the wrap uses the old pending state.
  - A load in the same cycle as i_clear: the clear applies the previously pending value (if any), and the new value becomes pending.
- Arithmetic:
  - All compares are unsigned, CNT_W wide.
  - c never exceeds P-1 because P changes only at c=0.
- Reset mid-operation:
  - Asynchronous; all state returns to reset values immediately, including discarding any pending load.

Optional Feature:
Macro CLKDIV_DIGIT_SEL_EN.
- Defined: adds output o_digit_sel [1:0].
  - Reset 0. Increments on every cycle where o_tick=1, wrapping 3->0.
  - i_clear zeroes it.
  - Drives a 4-digit display scan directly.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- DIV_DEFAULT=10, release reset, i_en=1 -> o_clk low 5 / high 5 cycles repeating; o_tick pulses at cycle 10, 20, 30; o_div_active=10.
- Pulse i_div_load with i_div=7 at c=3 -> o_load_pending=1 until the wrap at cycle 10, then o_div_active=7, low 4 / high 3, ticks every 7 cycles; no short pulse at the switch.
- Load i_div=0, then i_div=1, before the next wrap -> o_div_active=2 after the wrap; o_clk toggles every cycle, tick every 2 cycles.
- P=10, drop i_en for 3 cycles at c=6 -> o_clk held at 1, no tick; the period containing the pause lasts 13 cycles and the next period is 10.
- Assert i_clear at c=7 with pending divisor 4 -> next cycle c=0, o_clk=0, o_div_active=4, no tick; the following tick comes 4 cycles later.
- Assert i_reset_n=0 asynchronously at c=8 (o_clk=1) with a load pending -> o_clk=0 and o_tick=0 immediately, o_div_active=10, o_load_pending=0; with CLKDIV_DIGIT_SEL_EN, o_digit_sel=0 and it counts 0,1,2,3,0 on successive ticks after release.
